// File: rtl/bsg_fsb_node_iso_ctrl_fsb_domain.sv
// rtl/bsg_fsb_node_iso_ctrl_fsb_domain.sv - fsb-side power isolation controller with f2n/n2f FIFOs
// Holds the node in reset/isolation, wakes it on request, and drains node-bound traffic before isolating.

module bsg_fsb_node_iso_fifo #(
    parameter int width_p = 80,
    parameter int els_p   = 2
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               flush_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);
    localparam int PW = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int CW = $clog2(els_p + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(els_p - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(els_p);

    logic [width_p-1:0] r_mem [els_p];
    logic [PW-1:0]      r_wptr;
    logic [PW-1:0]      r_rptr;
    logic [CW-1:0]      r_count;
    logic               w_enq;
    logic               w_deq;

    // Ready looks only at full, so a full FIFO never accepts even during a dequeue.
    assign ready_o = (r_count != FULL_CNT);
    assign v_o     = (r_count != '0);
    assign data_o  = r_mem[r_rptr];
    assign w_enq   = v_i & ready_o;
    assign w_deq   = yumi_i & v_o;

    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            r_mem[r_wptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_wptr <= (r_wptr == LAST_PTR) ? '0 : r_wptr + 1'b1;
            end
            if (w_deq) begin
                r_rptr <= (r_rptr == LAST_PTR) ? '0 : r_rptr + 1'b1;
            end
            if (w_enq && !w_deq) begin
                r_count <= r_count + 1'b1;
            end else if (!w_enq && w_deq) begin
                r_count <= r_count - 1'b1;
            end
        end
    end
endmodule

module bsg_fsb_node_iso_ctrl_fsb_domain #(
    parameter int ring_width_p    = 80,
    parameter int els_p           = 2,
    parameter int wake_cycles_p   = 4,
    parameter int drain_timeout_p = 16
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    pwr_up_req_i,
    output logic                    en_ls_o,
    output logic                    node_reset_o,
    output logic                    iso_o,
    output logic                    drain_timeout_o,
    input  logic                    fsb_v_i,
    input  logic [ring_width_p-1:0] fsb_data_i,
    output logic                    fsb_ready_o,
    output logic                    node_v_o,
    output logic [ring_width_p-1:0] node_data_o,
    input  logic                    node_yumi_i,
    input  logic                    node_v_i,
    input  logic [ring_width_p-1:0] node_data_i,
    output logic                    node_ready_o,
    output logic                    fsb_v_o,
    output logic [ring_width_p-1:0] fsb_data_o,
    input  logic                    fsb_yumi_i
);
    localparam int WCW = $clog2(wake_cycles_p + 1);
    localparam int DCW = $clog2(drain_timeout_p + 1);
    localparam logic [WCW-1:0] WAKE_LAST  = WCW'(wake_cycles_p - 1);
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(drain_timeout_p - 1);

    typedef enum logic [1:0] {
        ST_ISO    = 2'd0,
        ST_WAKE   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [WCW-1:0]     r_wake_cnt;
    logic [DCW-1:0]     r_drain_cnt;
    logic               r_en_ls;
    logic               r_node_reset;
    logic               r_iso;
    logic               r_drain_timeout;
    logic               w_flush;
    logic               w_timeout;
    logic               w_active;

    logic               w_f2n_v_in;
    logic               w_f2n_ready;
    logic               w_f2n_v;
    logic [ring_width_p-1:0] w_f2n_data;
    logic               w_f2n_yumi;

    logic               w_n2f_v_in;
    logic [ring_width_p-1:0] w_n2f_data_in;
    logic               w_n2f_ready;

    always_comb begin
        w_state_next = r_state;
        w_flush      = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            ST_ISO: begin
                if (pwr_up_req_i) begin
                    w_state_next = ST_WAKE;
                end
            end
            ST_WAKE: begin
                if (!pwr_up_req_i) begin
                    w_state_next = ST_ISO;
                end else if (r_wake_cnt == WAKE_LAST) begin
                    w_state_next = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (!pwr_up_req_i) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // A renewed request cancels the drain before emptiness or timeout are considered.
                if (pwr_up_req_i) begin
                    w_state_next = ST_ACTIVE;
                end else if (!w_f2n_v) begin
                    w_state_next = ST_ISO;
                end else if (r_drain_cnt == DRAIN_LAST) begin
                    w_state_next = ST_ISO;
                    w_flush      = 1'b1;
                    w_timeout    = 1'b1;
                end
            end
            default: w_state_next = ST_ISO;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= ST_ISO;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_wake_cnt  <= '0;
            r_drain_cnt <= '0;
        end else begin
            if (r_state == ST_ISO && w_state_next == ST_WAKE) begin
                r_wake_cnt <= '0;
            end else if (r_state == ST_WAKE && r_wake_cnt != WAKE_LAST) begin
                r_wake_cnt <= r_wake_cnt + 1'b1;
            end
            if (r_state == ST_ACTIVE && w_state_next == ST_DRAIN) begin
                r_drain_cnt <= '0;
            end else if (r_state == ST_DRAIN && r_drain_cnt != DRAIN_LAST) begin
                r_drain_cnt <= r_drain_cnt + 1'b1;
            end
        end
    end

    // Status outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_en_ls         <= 1'b0;
            r_node_reset    <= 1'b1;
            r_iso           <= 1'b1;
            r_drain_timeout <= 1'b0;
        end else begin
            r_en_ls         <= (w_state_next == ST_ACTIVE) || (w_state_next == ST_DRAIN);
            r_node_reset    <= (w_state_next == ST_ISO) || (w_state_next == ST_WAKE);
            r_iso           <= (w_state_next == ST_ISO);
            r_drain_timeout <= w_timeout;
        end
    end

    assign en_ls_o         = r_en_ls;
    assign node_reset_o    = r_node_reset;
    assign iso_o           = r_iso;
    assign drain_timeout_o = r_drain_timeout;

    assign w_active    = (r_state == ST_ACTIVE);
    assign w_f2n_v_in  = fsb_v_i & w_active;
    assign fsb_ready_o = w_active & w_f2n_ready;
    assign node_v_o    = r_en_ls & w_f2n_v;
    assign node_data_o = w_f2n_data & {ring_width_p{r_en_ls}};
    assign w_f2n_yumi  = node_yumi_i & node_v_o;

    bsg_fsb_node_iso_fifo #(
        .width_p (ring_width_p),
        .els_p   (els_p)
    ) u_f2n_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .flush_i   (w_flush),
        .v_i       (w_f2n_v_in),
        .data_i    (fsb_data_i),
        .ready_o   (w_f2n_ready),
        .v_o       (w_f2n_v),
        .data_o    (w_f2n_data),
        .yumi_i    (w_f2n_yumi)
    );

    // Node-side inputs are gated so an isolated node cannot inject anything.
    assign w_n2f_v_in    = node_v_i & r_en_ls;
    assign w_n2f_data_in = node_data_i & {ring_width_p{r_en_ls}};
    assign node_ready_o  = r_en_ls & w_n2f_ready;

    bsg_fsb_node_iso_fifo #(
        .width_p (ring_width_p),
        .els_p   (els_p)
    ) u_n2f_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .flush_i   (1'b0),
        .v_i       (w_n2f_v_in),
        .data_i    (w_n2f_data_in),
        .ready_o   (w_n2f_ready),
        .v_o       (fsb_v_o),
        .data_o    (fsb_data_o),
        .yumi_i    (fsb_yumi_i)
    );
endmodule

// File: tb/tb_bsg_fsb_node_iso_ctrl_fsb_domain.sv
// tb/tb_bsg_fsb_node_iso_ctrl_fsb_domain.sv - self-checking bench with queue-based reference model
module tb_bsg_fsb_node_iso_ctrl_fsb_domain;
    localparam int W    = 80;
    localparam int ELS  = 2;
    localparam int WAKE = 4;
    localparam int TO   = 16;
    localparam int M_ISO = 0, M_WAKE = 1, M_ACT = 2, M_DRAIN = 3;

    logic         clk = 1'b0;
    logic         reset_n_i;
    logic         pwr_up_req_i;
    logic         en_ls_o, node_reset_o, iso_o, drain_timeout_o;
    logic         fsb_v_i, fsb_ready_o, node_v_o, node_yumi_i;
    logic         node_v_i, node_ready_o, fsb_v_o, fsb_yumi_i;
    logic [W-1:0] fsb_data_i, node_data_o, node_data_i, fsb_data_o;

    int total = 0;
    int bad   = 0;

    int           m_mode;
    int           m_wcnt;
    int           m_dcnt;
    bit           m_to;
    logic [W-1:0] f2n_q[$];
    logic [W-1:0] n2f_q[$];

    bsg_fsb_node_iso_ctrl_fsb_domain #(
        .ring_width_p    (W),
        .els_p           (ELS),
        .wake_cycles_p   (WAKE),
        .drain_timeout_p (TO)
    ) dut (
        .clk_i           (clk),
        .reset_n_i       (reset_n_i),
        .pwr_up_req_i    (pwr_up_req_i),
        .en_ls_o         (en_ls_o),
        .node_reset_o    (node_reset_o),
        .iso_o           (iso_o),
        .drain_timeout_o (drain_timeout_o),
        .fsb_v_i         (fsb_v_i),
        .fsb_data_i      (fsb_data_i),
        .fsb_ready_o     (fsb_ready_o),
        .node_v_o        (node_v_o),
        .node_data_o     (node_data_o),
        .node_yumi_i     (node_yumi_i),
        .node_v_i        (node_v_i),
        .node_data_i     (node_data_i),
        .node_ready_o    (node_ready_o),
        .fsb_v_o         (fsb_v_o),
        .fsb_data_o      (fsb_data_o),
        .fsb_yumi_i      (fsb_yumi_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_en();
        return (m_mode == M_ACT) || (m_mode == M_DRAIN);
    endfunction

    function automatic logic [W-1:0] rnd_word();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[W-1:0];
    endfunction

    task automatic model_reset();
        m_mode = M_ISO;
        m_wcnt = 0;
        m_dcnt = 0;
        m_to   = 1'b0;
        f2n_q.delete();
        n2f_q.delete();
    endtask

    task automatic compare_all();
        chk("en_ls", en_ls_o, m_en());
        chk("node_reset", node_reset_o, (m_mode == M_ISO) || (m_mode == M_WAKE));
        chk("iso", iso_o, m_mode == M_ISO);
        chk("drain_to", drain_timeout_o, m_to);
        chk("fsb_ready", fsb_ready_o, (m_mode == M_ACT) && (f2n_q.size() < ELS));
        chk("node_v", node_v_o, m_en() && (f2n_q.size() > 0));
        if (!m_en()) chk("node_data_zero", node_data_o, '0);
        else if (f2n_q.size() > 0) chk("node_data", node_data_o, f2n_q[0]);
        chk("node_ready", node_ready_o, m_en() && (n2f_q.size() < ELS));
        chk("fsb_v", fsb_v_o, n2f_q.size() > 0);
        if (n2f_q.size() > 0) chk("fsb_data", fsb_data_o, n2f_q[0]);
    endtask

    // Predicts the effect of the next rising edge from the current inputs.
    task automatic model_step();
        bit en, f_enq, f_deq, n_enq, n_deq, flush;
        int nm;
        en    = m_en();
        f_enq = fsb_v_i && (m_mode == M_ACT) && (f2n_q.size() < ELS);
        f_deq = node_yumi_i && en && (f2n_q.size() > 0);
        n_enq = node_v_i && en && (n2f_q.size() < ELS);
        n_deq = fsb_yumi_i && (n2f_q.size() > 0);
        nm    = m_mode;
        flush = 1'b0;
        case (m_mode)
            M_ISO: if (pwr_up_req_i) begin nm = M_WAKE; m_wcnt = 0; end
            M_WAKE: begin
                if (!pwr_up_req_i) nm = M_ISO;
                else if (m_wcnt == WAKE - 1) nm = M_ACT;
                else m_wcnt++;
            end
            M_ACT: if (!pwr_up_req_i) begin nm = M_DRAIN; m_dcnt = 0; end
            default: begin
                if (pwr_up_req_i) nm = M_ACT;
                else if (f2n_q.size() == 0) nm = M_ISO;
                else if (m_dcnt == TO - 1) begin nm = M_ISO; flush = 1'b1; end
                else m_dcnt++;
            end
        endcase
        if (f_deq) void'(f2n_q.pop_front());
        if (f_enq) f2n_q.push_back(fsb_data_i);
        if (n_deq) void'(n2f_q.pop_front());
        if (n_enq) n2f_q.push_back(node_data_i);
        if (flush) f2n_q.delete();
        m_to   = flush;
        m_mode = nm;
    endtask

    task automatic tick();
        compare_all();
        model_step();
        @(negedge clk);
    endtask

    task automatic go_active();
        int n;
        pwr_up_req_i = 1'b1;
        n = 0;
        while (en_ls_o !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("go_active", en_ls_o, 1'b1);
    endtask

    initial begin
        int n, pulses, seen_en;
        logic [W-1:0] w1, w2, w3, nw;
        reset_n_i = 1'b0;
        pwr_up_req_i = 0; fsb_v_i = 0; node_yumi_i = 0; node_v_i = 0; fsb_yumi_i = 0;
        fsb_data_i = '0; node_data_i = '0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        reset_n_i = 1'b1;

        // Wake latency: en_ls_o first seen in cycle 5, fsb_ready_o low during WAKE.
        pwr_up_req_i = 1'b1;
        n = 0;
        while (en_ls_o !== 1'b1 && n < 20) begin
            if (n > 0) chk("wake_ready", fsb_ready_o, 1'b0);
            tick();
            n++;
        end
        chk("wake_lat", n, 5);
        chk("wake_nreset", node_reset_o, 1'b0);

        // Backpressure with two-deep FIFO.
        w1 = rnd_word(); w2 = rnd_word(); w3 = rnd_word();
        fsb_v_i = 1; fsb_data_i = w1; tick();
        fsb_data_i = w2; tick();
        chk("full_ready", fsb_ready_o, 1'b0);
        fsb_data_i = w3; tick();
        fsb_v_i = 0; node_yumi_i = 1;
        chk("order_w1", node_data_o, w1);
        tick();
        chk("order_w2", node_data_o, w2);
        tick();
        node_yumi_i = 0;
        chk("order_empty", node_v_o, 1'b0);

        // Clean drain.
        fsb_v_i = 1; fsb_data_i = rnd_word(); tick();
        fsb_v_i = 0; pwr_up_req_i = 0;
        repeat (3) tick();
        node_yumi_i = 1; tick();
        node_yumi_i = 0;
        n = 0; pulses = 0;
        while (iso_o !== 1'b1 && n < 20) begin
            pulses += drain_timeout_o;
            tick();
            n++;
        end
        pulses += drain_timeout_o;
        chk("clean_iso_lat", n, 1);
        chk("clean_to", pulses, 0);

        // Aborted wake.
        pwr_up_req_i = 1; seen_en = 0;
        repeat (2) tick();
        pwr_up_req_i = 0;
        repeat (8) begin seen_en |= en_ls_o; tick(); end
        chk("abort_en", seen_en, 0);
        chk("abort_iso", iso_o, 1'b1);

        // Drain timeout with a stuck node.
        go_active();
        fsb_v_i = 1; fsb_data_i = rnd_word(); tick();
        fsb_data_i = rnd_word(); tick();
        fsb_v_i = 0; pwr_up_req_i = 0;
        n = 0;
        while (drain_timeout_o !== 1'b1 && n < 40) begin tick(); n++; end
        chk("to_lat", n, 17);
        chk("to_iso", iso_o, 1'b1);
        chk("to_node_v", node_v_o, 1'b0);
        chk("to_node_data", node_data_o, '0);
        tick();
        chk("to_pulse_once", drain_timeout_o, 1'b0);

        // n2f word survives isolation; isolated node cannot enqueue.
        go_active();
        nw = rnd_word();
        node_v_i = 1; node_data_i = nw; tick();
        node_v_i = 0; pwr_up_req_i = 0;
        n = 0;
        while (iso_o !== 1'b1 && n < 20) begin tick(); n++; end
        node_v_i = 1; node_data_i = rnd_word();
        repeat (3) begin
            chk("iso_fsb_v", fsb_v_o, 1'b1);
            chk("iso_node_ready", node_ready_o, 1'b0);
            tick();
        end
        node_v_i = 0; fsb_yumi_i = 1;
        chk("iso_fsb_data", fsb_data_o, nw);
        tick();
        fsb_yumi_i = 0;
        chk("iso_drained", fsb_v_o, 1'b0);

        // Randomized traffic and power requests.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) pwr_up_req_i = ~pwr_up_req_i;
            fsb_v_i     = $urandom_range(0, 1);
            fsb_data_i  = rnd_word();
            node_yumi_i = ($urandom_range(0, 3) != 0);
            node_v_i    = $urandom_range(0, 1);
            node_data_i = rnd_word();
            fsb_yumi_i  = $urandom_range(0, 1);
            tick();
        end

        // Mid-burst reset between clock edges.
        pwr_up_req_i = 1; fsb_v_i = 1; node_v_i = 1;
        node_yumi_i = 0; fsb_yumi_i = 0;
        go_active();
        tick();
        #2 reset_n_i = 1'b0;
        #1;
        model_reset();
        chk("rst_fsb_v", fsb_v_o, 1'b0);
        chk("rst_node_v", node_v_o, 1'b0);
        chk("rst_fsb_ready", fsb_ready_o, 1'b0);
        chk("rst_node_ready", node_ready_o, 1'b0);
        chk("rst_node_data", node_data_o, '0);
        compare_all();
        @(negedge clk);
        compare_all();
        reset_n_i = 1'b1;
        pwr_up_req_i = 0; fsb_v_i = 0; node_v_i = 0;
        repeat (5) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
